fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined CPU, directly upstream of dec_stage. It owns the PC and issues word-addressed reads to a synchronous instruction memory (1-cycle read latency). It feeds the IF/ID register (inst, inst_pc, inst_valid) that dec_stage consumes. It absorbs hazard-unit stalls with a one-entry skid buffer and handles branch/RET redirects and HALT.

---
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory, hazard/redirect and IF/ID signal bundle
//               for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        fetch_halted;

    modport master (
        output imem_en, imem_addr, inst, inst_pc, inst_valid, fetch_halted,
        input  imem_rdata, stall, redirect_en, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, inst, inst_pc, inst_valid, fetch_halted,
        output imem_rdata, stall, redirect_en, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : PC owner and IF/ID producer with one-entry skid, redirect
//               and HALT handling.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = 4'h1,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    fetch_stage_if.master  bus
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_pc;
    logic        r_inflight;
    logic [15:0] r_inflight_pc;
    logic        r_skid_valid;
    logic [15:0] r_skid_inst;
    logic [15:0] r_skid_pc;
    logic [15:0] r_inst;
    logic [15:0] r_inst_pc;
    logic        r_inst_valid;

    logic        w_imem_en;
    logic [15:0] w_imem_addr;
    logic        w_load;
    logic [15:0] w_load_inst;
    logic [15:0] w_load_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // Redirect outranks stall and HALTED; the skid drains before new responses.
    always_comb begin
        w_state_nxt = r_state;
        w_imem_en   = 1'b0;
        w_imem_addr = r_pc;
        w_load      = 1'b0;
        w_load_inst = NOP_INST;
        w_load_pc   = r_inst_pc;
        if (bus.redirect_en) begin
            w_imem_en   = 1'b1;
            w_imem_addr = bus.redirect_pc;
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_RUN) begin
            if (!bus.stall && !r_skid_valid) begin
                w_imem_en = 1'b1;
            end
            if (!bus.stall) begin
                if (r_skid_valid) begin
                    w_load      = 1'b1;
                    w_load_inst = r_skid_inst;
                    w_load_pc   = r_skid_pc;
                end else if (r_inflight) begin
                    w_load      = 1'b1;
                    w_load_inst = bus.imem_rdata;
                    w_load_pc   = r_inflight_pc;
                end
            end
            if (w_load && (w_load_inst[15:12] == HALT_OP)) begin
                w_state_nxt = ST_HALTED;
            end
        end
        if (!rst_n) begin
            w_imem_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 16'h0000;
            r_skid_valid  <= 1'b0;
            r_skid_inst   <= NOP_INST;
            r_skid_pc     <= 16'h0000;
            r_inst        <= NOP_INST;
            r_inst_pc     <= 16'h0000;
            r_inst_valid  <= 1'b0;
        end else begin
            r_inflight    <= w_imem_en;
            r_inflight_pc <= w_imem_addr;
            if (bus.redirect_en) begin
                r_pc <= bus.redirect_pc + 16'd1;
            end else if (w_imem_en) begin
                r_pc <= r_pc + 16'd1;
            end

            // A response arriving in a redirect or HALTED cycle is simply dropped.
            if (bus.redirect_en) begin
                r_inst_valid <= 1'b0;
                r_inst       <= NOP_INST;
                r_skid_valid <= 1'b0;
            end else if (r_state == ST_HALTED) begin
                r_skid_valid <= 1'b0;
                if (!bus.stall) begin
                    r_inst_valid <= 1'b0;
                    r_inst       <= NOP_INST;
                end
            end else if (!bus.stall) begin
                r_skid_valid <= 1'b0;
                if (w_load) begin
                    r_inst_valid <= 1'b1;
                    r_inst       <= w_load_inst;
                    r_inst_pc    <= w_load_pc;
                end else begin
                    r_inst_valid <= 1'b0;
                    r_inst       <= NOP_INST;
                end
            end else if (r_inflight) begin
                r_skid_valid <= 1'b1;
                r_skid_inst  <= bus.imem_rdata;
                r_skid_pc    <= r_inflight_pc;
            end
        end
    end

    assign bus.imem_en      = w_imem_en;
    assign bus.imem_addr    = w_imem_addr;
    assign bus.inst         = r_inst;
    assign bus.inst_pc      = r_inst_pc;
    assign bus.inst_valid   = r_inst_valid;
    assign bus.fetch_halted = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC (16'h0000),
        .HALT_OP  (4'h1),
        .NOP_INST (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: word 7 holds a HALT, everything else 3000+addr.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] v;
        if (a == 16'h0007) v = 16'h1000;
        else               v = 16'h3000 + a;
        return v;
    endfunction

    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= mem_word(bus.imem_addr);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 16'h0000;
        repeat (3) tick();
        #1;
        total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b0, 16'h0000, 16'h0000})
            $display("FAIL reset_ifid got v=%b inst=%h pc=%h exp v=0 inst=0000 pc=0000", bus.inst_valid, bus.inst, bus.inst_pc);
        else pass_cnt++;
        total_cnt++; if ({bus.imem_en, bus.fetch_halted} !== 2'b00)
            $display("FAIL reset_en_halt got en=%b halted=%b exp en=0 halted=0", bus.imem_en, bus.fetch_halted);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [15:0] e_inst;
        logic [15:0] e_pc;
        rst_n = 1'b1;
        #1;
        total_cnt++; if ({bus.imem_en, bus.imem_addr} !== {1'b1, 16'h0000})
            $display("FAIL stream_first_req got en=%b addr=%h exp en=1 addr=0000", bus.imem_en, bus.imem_addr);
        else pass_cnt++;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total_cnt++; if ({bus.imem_en, bus.imem_addr} !== {1'b1, 16'(i)})
                $display("FAIL stream_addr got en=%b addr=%h exp en=1 addr=%h", bus.imem_en, bus.imem_addr, 16'(i));
            else pass_cnt++;
            if (i == 1) begin
                total_cnt++; if (bus.inst_valid !== 1'b0)
                    $display("FAIL stream_valid_early got %b exp 0", bus.inst_valid);
                else pass_cnt++;
            end else begin
                e_pc   = 16'(i - 2);
                e_inst = 16'h3000 + e_pc;
                total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, e_inst, e_pc})
                    $display("FAIL stream_inst got v=%b inst=%h pc=%h exp v=1 inst=%h pc=%h", bus.inst_valid, bus.inst, bus.inst_pc, e_inst, e_pc);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        #1;
        total_cnt++; if (bus.imem_en !== 1'b0)
            $display("FAIL stall_en_first got %b exp 0", bus.imem_en);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_en} !== {1'b1, 16'h3002, 16'h0002, 1'b0})
                $display("FAIL stall_hold got v=%b inst=%h pc=%h en=%b exp v=1 inst=3002 pc=0002 en=0", bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_en);
            else pass_cnt++;
        end
        bus.stall = 1'b0;
        #1;
        total_cnt++; if (bus.imem_en !== 1'b0)
            $display("FAIL stall_skid_block got en=%b exp 0", bus.imem_en);
        else pass_cnt++;
        tick();
        total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 16'h3003, 16'h0003})
            $display("FAIL stall_skid_out got v=%b inst=%h pc=%h exp v=1 inst=3003 pc=0003", bus.inst_valid, bus.inst, bus.inst_pc);
        else pass_cnt++;
        total_cnt++; if ({bus.imem_en, bus.imem_addr} !== {1'b1, 16'h0004})
            $display("FAIL stall_resume_req got en=%b addr=%h exp en=1 addr=0004", bus.imem_en, bus.imem_addr);
        else pass_cnt++;
        tick();
        total_cnt++; if ({bus.inst_valid, bus.inst} !== {1'b0, 16'h0000})
            $display("FAIL stall_bubble got v=%b inst=%h exp v=0 inst=0000", bus.inst_valid, bus.inst);
        else pass_cnt++;
        tick();
        total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 16'h3004, 16'h0004})
            $display("FAIL stall_next got v=%b inst=%h pc=%h exp v=1 inst=3004 pc=0004", bus.inst_valid, bus.inst, bus.inst_pc);
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 16'h0040;
        #1;
        total_cnt++; if ({bus.imem_en, bus.imem_addr} !== {1'b1, 16'h0040})
            $display("FAIL redir_req got en=%b addr=%h exp en=1 addr=0040", bus.imem_en, bus.imem_addr);
        else pass_cnt++;
        tick();
        bus.redirect_en = 1'b0;
        total_cnt++; if ({bus.inst_valid, bus.inst} !== {1'b0, 16'h0000})
            $display("FAIL redir_squash got v=%b inst=%h exp v=0 inst=0000", bus.inst_valid, bus.inst);
        else pass_cnt++;
        tick();
        total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 16'h3040, 16'h0040})
            $display("FAIL redir_target got v=%b inst=%h pc=%h exp v=1 inst=3040 pc=0040", bus.inst_valid, bus.inst, bus.inst_pc);
        else pass_cnt++;
        tick();
        total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 16'h3041, 16'h0041})
            $display("FAIL redir_next got v=%b inst=%h pc=%h exp v=1 inst=3041 pc=0041", bus.inst_valid, bus.inst, bus.inst_pc);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        int bad;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 16'h0005;
        tick();
        bus.redirect_en = 1'b0;
        tick();
        total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 16'h3005, 16'h0005})
            $display("FAIL halt_pre got v=%b inst=%h pc=%h exp v=1 inst=3005 pc=0005", bus.inst_valid, bus.inst, bus.inst_pc);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 16'h1000, 16'h0007})
            $display("FAIL halt_inst got v=%b inst=%h pc=%h exp v=1 inst=1000 pc=0007", bus.inst_valid, bus.inst, bus.inst_pc);
        else pass_cnt++;
        total_cnt++; if ({bus.fetch_halted, bus.imem_en} !== 2'b10)
            $display("FAIL halt_state got halted=%b en=%b exp halted=1 en=0", bus.fetch_halted, bus.imem_en);
        else pass_cnt++;
        tick();
        total_cnt++; if ({bus.inst_valid, bus.inst, bus.fetch_halted} !== {1'b0, 16'h0000, 1'b1})
            $display("FAIL halt_drop got v=%b inst=%h halted=%b exp v=0 inst=0000 halted=1", bus.inst_valid, bus.inst, bus.fetch_halted);
        else pass_cnt++;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.imem_en !== 1'b0 || bus.inst_valid !== 1'b0) bad++;
        end
        total_cnt++; if (bad != 0)
            $display("FAIL halt_idle got %0d active cycles exp 0", bad);
        else pass_cnt++;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 16'h0010;
        #1;
        total_cnt++; if ({bus.imem_en, bus.imem_addr} !== {1'b1, 16'h0010})
            $display("FAIL halt_exit_req got en=%b addr=%h exp en=1 addr=0010", bus.imem_en, bus.imem_addr);
        else pass_cnt++;
        tick();
        bus.redirect_en = 1'b0;
        total_cnt++; if ({bus.fetch_halted, bus.inst_valid} !== 2'b00)
            $display("FAIL halt_exit_state got halted=%b v=%b exp halted=0 v=0", bus.fetch_halted, bus.inst_valid);
        else pass_cnt++;
        tick();
        total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 16'h3010, 16'h0010})
            $display("FAIL halt_exit_inst got v=%b inst=%h pc=%h exp v=1 inst=3010 pc=0010", bus.inst_valid, bus.inst, bus.inst_pc);
        else pass_cnt++;
    endtask

    task automatic test_redirect_stall();
        bus.stall       = 1'b1;
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 16'h0020;
        #1;
        total_cnt++; if ({bus.imem_en, bus.imem_addr} !== {1'b1, 16'h0020})
            $display("FAIL rs_req got en=%b addr=%h exp en=1 addr=0020", bus.imem_en, bus.imem_addr);
        else pass_cnt++;
        tick();
        bus.stall       = 1'b0;
        bus.redirect_en = 1'b0;
        total_cnt++; if ({bus.inst_valid, bus.inst} !== {1'b0, 16'h0000})
            $display("FAIL rs_clear got v=%b inst=%h exp v=0 inst=0000", bus.inst_valid, bus.inst);
        else pass_cnt++;
        tick();
        total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 16'h3020, 16'h0020})
            $display("FAIL rs_target got v=%b inst=%h pc=%h exp v=1 inst=3020 pc=0020", bus.inst_valid, bus.inst, bus.inst_pc);
        else pass_cnt++;
    endtask

    task automatic test_wrap_reset();
        bus.redirect_en = 1'b1;
        bus.redirect_pc = 16'hFFFE;
        tick();
        bus.redirect_en = 1'b0;
        total_cnt++; if (bus.inst_valid !== 1'b0)
            $display("FAIL wrap_squash got v=%b exp 0", bus.inst_valid);
        else pass_cnt++;
        tick();
        total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 16'h2FFE, 16'hFFFE})
            $display("FAIL wrap_fffe got v=%b inst=%h pc=%h exp v=1 inst=2ffe pc=fffe", bus.inst_valid, bus.inst, bus.inst_pc);
        else pass_cnt++;
        tick();
        total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 16'h2FFF, 16'hFFFF})
            $display("FAIL wrap_ffff got v=%b inst=%h pc=%h exp v=1 inst=2fff pc=ffff", bus.inst_valid, bus.inst, bus.inst_pc);
        else pass_cnt++;
        tick();
        total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 16'h3000, 16'h0000})
            $display("FAIL wrap_0000 got v=%b inst=%h pc=%h exp v=1 inst=3000 pc=0000", bus.inst_valid, bus.inst, bus.inst_pc);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.imem_en !== 1'b0)
            $display("FAIL mid_reset_en got %b exp 0", bus.imem_en);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        total_cnt++; if ({bus.inst_valid, bus.inst_pc, bus.fetch_halted} !== {1'b0, 16'h0000, 1'b0})
            $display("FAIL mid_reset_state got v=%b pc=%h halted=%b exp v=0 pc=0000 halted=0", bus.inst_valid, bus.inst_pc, bus.fetch_halted);
        else pass_cnt++;
        #1;
        total_cnt++; if ({bus.imem_en, bus.imem_addr} !== {1'b1, 16'h0000})
            $display("FAIL mid_reset_req got en=%b addr=%h exp en=1 addr=0000", bus.imem_en, bus.imem_addr);
        else pass_cnt++;
        tick();
        total_cnt++; if ({bus.inst_valid, bus.imem_addr} !== {1'b0, 16'h0001})
            $display("FAIL mid_reset_gap got v=%b addr=%h exp v=0 addr=0001", bus.inst_valid, bus.imem_addr);
        else pass_cnt++;
        tick();
        total_cnt++; if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, 16'h3000, 16'h0000})
            $display("FAIL mid_reset_first got v=%b inst=%h pc=%h exp v=1 inst=3000 pc=0000", bus.inst_valid, bus.inst, bus.inst_pc);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_redirect_stall();
        test_wrap_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
